// File: rtl/game_sequencer.sv
// Central Flappy Bird game controller: game state machine, per-frame bird
// physics (y position and signed velocity) and a saturating BCD score.
// Ports:
//   clk         system clock
//   clr         asynchronous active-low reset
//   frame_tick  one-cycle pulse per video frame
//   flap        raw pushbutton (asynchronous)
//   pause       raw pushbutton (asynchronous)
//   collide     level from renderer, bird overlaps a pipe
//   pipe_pass   one-cycle pulse, bird cleared a pipe
//   bird_y      bird top y in pixels
//   state       00 IDLE, 01 PLAY, 10 PAUSE, 11 DEAD
//   gamestate   high only in PLAY
//   scroll_en   high only in PLAY (pipes move)
//   score       four BCD digits, [15:12] most significant
module game_sequencer #(
   parameter int unsigned START_Y     = 240,
   parameter int unsigned FLOOR_Y     = 440,
   parameter int unsigned GRAVITY     = 1,
   parameter int unsigned FLAP_VEL    = 8,
   parameter int unsigned MAX_FALL    = 10,
   parameter int unsigned DEAD_FRAMES = 60
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        frame_tick,
   input  logic        flap,
   input  logic        pause,
   input  logic        collide,
   input  logic        pipe_pass,
   output logic [9:0]  bird_y,
   output logic [1:0]  state,
   output logic        gamestate,
   output logic        scroll_en,
   output logic [15:0] score
);

   localparam int unsigned YW  = 10;
   localparam int unsigned VW  = 8;
   localparam int unsigned SW  = 11;
   localparam int unsigned SCW = 16;
   localparam int unsigned DCW = $clog2(DEAD_FRAMES + 1);

   localparam logic signed [VW-1:0] VEL_FLAP = -$signed(VW'(FLAP_VEL));
   localparam logic signed [VW-1:0] VEL_GRAV = $signed(VW'(GRAVITY));
   localparam logic signed [VW-1:0] VEL_MAX  = $signed(VW'(MAX_FALL));
   localparam logic signed [SW-1:0] SUM_FLOOR = $signed(SW'(FLOOR_Y));

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_PLAY  = 2'b01,
      S_PAUSE = 2'b10,
      S_DEAD  = 2'b11
   } state_t;

   state_t                state_q, state_d;
   logic [YW-1:0]         bird_y_q, bird_y_d;
   logic signed [VW-1:0]  vel_q, vel_d;
   logic                  pend_q, pend_d;
   logic [SCW-1:0]        score_q, score_d;
   logic [DCW-1:0]        dead_cnt_q, dead_cnt_d;
   logic [2:0]            flap_sr, pause_sr;

   logic                  flap_edge_c, pause_edge_c;
   logic signed [VW-1:0]  vel_inc_c, vel_tick_c;
   logic signed [SW-1:0]  sum_c;
   logic                  floor_c, ceil_c, dead_ready_c;

   // Saturating four-digit BCD increment with per-digit carry.
   function automatic logic [SCW-1:0] bcd_inc(input logic [SCW-1:0] s);
      logic [SCW-1:0] r;
      logic           c;
      r = s;
      c = 1'b1;
      if (s != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            if (c) begin
               if (r[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   // Two-flop synchronizers; bit 2 holds the previous synchronized level.
   assign flap_edge_c  = flap_sr[1]  & ~flap_sr[2];
   assign pause_edge_c = pause_sr[1] & ~pause_sr[2];

   // Velocity and position candidate for this frame tick.
   always_comb begin
      vel_inc_c  = vel_q + VEL_GRAV;
      vel_tick_c = (vel_inc_c > VEL_MAX) ? VEL_MAX : vel_inc_c;
      if (pend_q) begin
         vel_tick_c = VEL_FLAP;
      end
      sum_c        = $signed({1'b0, bird_y_q}) + SW'(vel_tick_c);
      floor_c      = (sum_c >= SUM_FLOOR);
      ceil_c       = (sum_c < $signed(SW'(0)));
      dead_ready_c = (dead_cnt_q == DCW'(DEAD_FRAMES));
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= S_IDLE;
         bird_y_q   <= YW'(START_Y);
         vel_q      <= '0;
         pend_q     <= 1'b0;
         score_q    <= '0;
         dead_cnt_q <= '0;
         flap_sr    <= '0;
         pause_sr   <= '0;
      end else begin
         state_q    <= state_d;
         bird_y_q   <= bird_y_d;
         vel_q      <= vel_d;
         pend_q     <= pend_d;
         score_q    <= score_d;
         dead_cnt_q <= dead_cnt_d;
         flap_sr    <= {flap_sr[1:0], flap};
         pause_sr   <= {pause_sr[1:0], pause};
      end
   end

   // Next-state logic; collide/floor outrank pause, which outranks flap.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (flap_edge_c) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (collide || (frame_tick && floor_c)) state_d = S_DEAD;
            else if (pause_edge_c)                  state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (pause_edge_c) state_d = S_PLAY;
         end
         S_DEAD: begin
            if (flap_edge_c && dead_ready_c) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values; everything holds unless the state says otherwise.
   always_comb begin
      bird_y_d   = bird_y_q;
      vel_d      = vel_q;
      pend_d     = pend_q;
      score_d    = score_q;
      dead_cnt_d = dead_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            bird_y_d   = YW'(START_Y);
            vel_d      = '0;
            pend_d     = 1'b0;
            dead_cnt_d = '0;
            if (flap_edge_c) begin
               score_d = '0;
               pend_d  = 1'b1;
            end
         end
         S_PLAY: begin
            if (pipe_pass) score_d = bcd_inc(score_q);
            if (collide) begin
               // bird freezes where it was hit
               pend_d     = 1'b0;
               dead_cnt_d = '0;
            end else if (frame_tick && floor_c) begin
               bird_y_d   = YW'(FLOOR_Y);
               vel_d      = vel_tick_c;
               pend_d     = 1'b0;
               dead_cnt_d = '0;
            end else begin
               if (frame_tick) begin
                  // a flap arriving with this tick waits for the next one
                  pend_d = flap_edge_c & ~pause_edge_c;
                  if (ceil_c) begin
                     bird_y_d = '0;
                     vel_d    = '0;
                  end else begin
                     bird_y_d = YW'(sum_c);
                     vel_d    = vel_tick_c;
                  end
               end else if (flap_edge_c && !pause_edge_c) begin
                  pend_d = 1'b1;
               end
            end
         end
         S_PAUSE: begin
         end
         S_DEAD: begin
            if (frame_tick && !dead_ready_c) dead_cnt_d = dead_cnt_q + DCW'(1);
            if (flap_edge_c && dead_ready_c) begin
               bird_y_d = YW'(START_Y);
               vel_d    = '0;
            end
         end
         default: begin
         end
      endcase
   end

   assign bird_y    = bird_y_q;
   assign state     = state_q;
   assign score     = score_q;
   assign gamestate = (state_q == S_PLAY);
   assign scroll_en = (state_q == S_PLAY);

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed scenarios plus randomized
// play, compared against an arithmetic game model kept in the bench.
module tb_game_sequencer;

   logic        clk = 1'b0;
   logic        clr, frame_tick, flap, pause, collide, pipe_pass;
   logic [9:0]  bird_y;
   logic [1:0]  state;
   logic        gamestate, scroll_en;
   logic [15:0] score;

   int n_cmp = 0;
   int n_bad = 0;

   // behavioural model
   int m_y, m_vel, m_pend, m_score, m_st, m_dead, m_clamp;

   game_sequencer dut (
      .clk(clk), .clr(clr), .frame_tick(frame_tick), .flap(flap),
      .pause(pause), .collide(collide), .pipe_pass(pipe_pass),
      .bird_y(bird_y), .state(state), .gamestate(gamestate),
      .scroll_en(scroll_en), .score(score)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press_flap();
      flap = 1'b1;
      repeat (4) step();
      flap = 1'b0;
      repeat (3) step();
   endtask

   task automatic press_pause();
      pause = 1'b1;
      repeat (4) step();
      pause = 1'b0;
      repeat (3) step();
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic pulse_pass();
      pipe_pass = 1'b1;
      step();
      pipe_pass = 1'b0;
      step();
   endtask

   task automatic hold_pass(input int n);
      pipe_pass = 1'b1;
      repeat (n) step();
      pipe_pass = 1'b0;
      step();
   endtask

   // Game rules applied to one frame tick.
   task automatic model_tick();
      int s;
      m_clamp = 0;
      if (m_st == 1) begin
         if (m_pend != 0) m_vel = -8;
         else m_vel = (m_vel + 1 > 10) ? 10 : m_vel + 1;
         m_pend = 0;
         s = m_y + m_vel;
         if (s < 0) begin
            m_y = 0; m_vel = 0; m_clamp = 1;
         end else if (s >= 440) begin
            m_y = 440; m_st = 3; m_dead = 0;
         end else begin
            m_y = s;
         end
      end else if (m_st == 3) begin
         if (m_dead < 60) m_dead++;
      end
   endtask

   task automatic test_reset();
      clr = 1'b0; frame_tick = 1'b0; flap = 1'b0; pause = 1'b0;
      collide = 1'b0; pipe_pass = 1'b0;
      repeat (2) step();
      clr = 1'b1;
      step();
      m_y = 240; m_vel = 0; m_pend = 0; m_score = 0; m_st = 0; m_dead = 0;
      n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state got %b want 00", state); end
      n_cmp++; if (bird_y !== 10'd240) begin n_bad++; $display("FAIL reset_y got %0d want 240", bird_y); end
      n_cmp++; if (score !== 16'h0000) begin n_bad++; $display("FAIL reset_score got %h want 0000", score); end
      n_cmp++; if ({gamestate, scroll_en} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {gamestate, scroll_en}); end
   endtask

   task automatic test_start();
      flap = 1'b1;
      step(); step();
      n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL start_early got %b want 00", state); end
      step();
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL start_edge got %b want 01", state); end
      step(); step();
      flap = 1'b0;
      repeat (3) step();
      m_st = 1; m_pend = 1; m_score = 0;
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL start_hold got %b want 01", state); end
      n_cmp++; if (score !== 16'h0000) begin n_bad++; $display("FAIL start_score got %h want 0000", score); end
      n_cmp++; if ({gamestate, scroll_en} !== 2'b11) begin n_bad++; $display("FAIL play_flags got %b want 11", {gamestate, scroll_en}); end
   endtask

   task automatic test_flap_arc();
      int exp_y[4] = '{232, 225, 219, 214};
      for (int i = 0; i < 4; i++) begin
         tick();
         model_tick();
         n_cmp++; if (bird_y !== 10'(exp_y[i])) begin n_bad++; $display("FAIL arc_y[%0d] got %0d want %0d", i, bird_y, exp_y[i]); end
      end
   endtask

   task automatic test_ceiling();
      int seen = 0;
      for (int k = 0; k < 80 && seen == 0; k++) begin
         press_flap();
         m_pend = 1;
         tick();
         model_tick();
         seen = m_clamp;
         n_cmp++; if (bird_y !== 10'(m_y)) begin n_bad++; $display("FAIL ceil_y[%0d] got %0d want %0d", k, bird_y, m_y); end
      end
      n_cmp++; if (seen == 0) begin n_bad++; $display("FAIL ceil_reached got 0 want 1"); end
      n_cmp++; if (bird_y !== 10'd0) begin n_bad++; $display("FAIL ceil_top got %0d want 0", bird_y); end
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL ceil_state got %b want 01", state); end
      // velocity was zeroed: next free tick moves exactly GRAVITY
      tick();
      model_tick();
      n_cmp++; if (bird_y !== 10'd1) begin n_bad++; $display("FAIL ceil_vel got %0d want 1", bird_y); end
   endtask

   task automatic test_random_play();
      int r;
      for (int k = 0; k < 60 && m_st == 1; k++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3) begin
            press_flap(); m_pend = 1;
         end else if (r < 8) begin
            tick(); model_tick();
         end else begin
            pulse_pass(); m_score++;
         end
         n_cmp++; if (bird_y !== 10'(m_y)) begin n_bad++; $display("FAIL rand_y[%0d] got %0d want %0d", k, bird_y, m_y); end
         n_cmp++; if (state !== 2'(m_st)) begin n_bad++; $display("FAIL rand_state[%0d] got %b want %0d", k, state, m_st); end
         n_cmp++; if (score !== to_bcd(m_score)) begin n_bad++; $display("FAIL rand_score[%0d] got %h want %h", k, score, to_bcd(m_score)); end
      end
   endtask

   task automatic test_fall_dead();
      for (int k = 0; k < 200 && m_st == 1; k++) begin
         tick();
         model_tick();
         n_cmp++; if (bird_y !== 10'(m_y)) begin n_bad++; $display("FAIL fall_y[%0d] got %0d want %0d", k, bird_y, m_y); end
      end
      n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL floor_state got %b want 11", state); end
      n_cmp++; if (bird_y !== 10'd440) begin n_bad++; $display("FAIL floor_y got %0d want 440", bird_y); end
      repeat (59) begin tick(); model_tick(); end
      press_flap();
      n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL dead_early got %b want 11", state); end
      n_cmp++; if (score !== to_bcd(m_score)) begin n_bad++; $display("FAIL dead_score got %h want %h", score, to_bcd(m_score)); end
      tick(); model_tick();
      press_flap();
      m_st = 0; m_y = 240; m_vel = 0; m_pend = 0;
      n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL dead_exit got %b want 00", state); end
      n_cmp++; if (bird_y !== 10'd240) begin n_bad++; $display("FAIL idle_y got %0d want 240", bird_y); end
   endtask

   task automatic test_score();
      int n;
      press_flap();
      m_st = 1; m_pend = 1; m_score = 0;
      n_cmp++; if (score !== 16'h0000) begin n_bad++; $display("FAIL score_clear got %h want 0000", score); end
      repeat (9) pulse_pass();
      n_cmp++; if (score !== 16'h0009) begin n_bad++; $display("FAIL score_9 got %h want 0009", score); end
      pulse_pass();
      n_cmp++; if (score !== 16'h0010) begin n_bad++; $display("FAIL score_10 got %h want 0010", score); end
      m_score = 10;
      for (int k = 0; k < 6; k++) begin
         n = int'($urandom_range(1, 120));
         hold_pass(n);
         m_score += n;
         n_cmp++; if (score !== to_bcd(m_score)) begin n_bad++; $display("FAIL score_burst[%0d] got %h want %h", k, score, to_bcd(m_score)); end
      end
      hold_pass(999 - m_score);
      n_cmp++; if (score !== 16'h0999) begin n_bad++; $display("FAIL score_999 got %h want 0999", score); end
      pulse_pass();
      n_cmp++; if (score !== 16'h1000) begin n_bad++; $display("FAIL score_1000 got %h want 1000", score); end
      hold_pass(9999 - 1000 + 5);
      m_score = 9999;
      n_cmp++; if (score !== 16'h9999) begin n_bad++; $display("FAIL score_sat got %h want 9999", score); end
      pulse_pass();
      n_cmp++; if (score !== 16'h9999) begin n_bad++; $display("FAIL score_sat2 got %h want 9999", score); end
   endtask

   task automatic test_pause();
      press_pause();
      n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL pause_enter got %b want 10", state); end
      n_cmp++; if ({gamestate, scroll_en} !== 2'b00) begin n_bad++; $display("FAIL pause_flags got %b want 00", {gamestate, scroll_en}); end
      repeat (3) tick();
      collide = 1'b1; repeat (2) step(); collide = 1'b0;
      pulse_pass();
      press_flap();
      n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL pause_hold got %b want 10", state); end
      n_cmp++; if (bird_y !== 10'(m_y)) begin n_bad++; $display("FAIL pause_y got %0d want %0d", bird_y, m_y); end
      n_cmp++; if (score !== to_bcd(m_score)) begin n_bad++; $display("FAIL pause_score got %h want %h", score, to_bcd(m_score)); end
      press_pause();
      n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL pause_exit got %b want 01", state); end
      n_cmp++; if (bird_y !== 10'(m_y)) begin n_bad++; $display("FAIL resume_y got %0d want %0d", bird_y, m_y); end
      // pending flap from game start survives the pause
      tick(); model_tick();
      n_cmp++; if (bird_y !== 10'(m_y)) begin n_bad++; $display("FAIL resume_tick got %0d want %0d", bird_y, m_y); end
      pause = 1'b1;
      step(); step();
      collide = 1'b1;
      step();
      collide = 1'b0;
      m_st = 3;
      n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL pause_vs_collide got %b want 11", state); end
      step();
      pause = 1'b0;
      repeat (3) step();
      n_cmp++; if (bird_y !== 10'(m_y)) begin n_bad++; $display("FAIL collide_freeze got %0d want %0d", bird_y, m_y); end
   endtask

   task automatic test_reset_midgame();
      step();
      clr = 1'b0;
      #2;
      n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL async_state got %b want 00", state); end
      n_cmp++; if (bird_y !== 10'd240) begin n_bad++; $display("FAIL async_y got %0d want 240", bird_y); end
      n_cmp++; if (score !== 16'h0000) begin n_bad++; $display("FAIL async_score got %h want 0000", score); end
      step();
      clr = 1'b1;
      m_st = 0; m_y = 240; m_vel = 0; m_pend = 0; m_score = 0;
      press_flap();
      m_st = 1; m_pend = 1;
      tick(); model_tick();
      n_cmp++; if (bird_y !== 10'(m_y)) begin n_bad++; $display("FAIL restart_y got %0d want %0d", bird_y, m_y); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_flap_arc();
      test_ceiling();
      test_random_play();
      test_fall_dead();
      test_score();
      test_pause();
      test_reset_midgame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
